// File: rtl/issue_sched.sv
// Issue scheduler: decides how many head entries of the instruction queue
// issue each cycle (none, one, or two), keeps a branch together with its
// delay slot, and lets serializing instructions issue alone and drain.
// Build option: define ISSUE_SCHED_DUAL_EN to allow dual issue; when it is
// undefined every grant is a single issue and every branch in RUN waits
// for its delay slot in WAIT_DS.
module issue_sched #(
  parameter int unsigned REG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [1:0]           iq_valid_i,
  input  logic [1:0]           is_branch_i,
  input  logic [1:0]           is_serial_i,
  input  logic [1:0][REG_W-1:0] src0_i,
  input  logic [1:0][REG_W-1:0] src1_i,
  input  logic [1:0][REG_W-1:0] dst_i,
  input  logic                 ds_ready_i,
  input  logic                 serial_done_i,
  output logic [1:0]           upd_mode_o,
  output logic [1:0]           issue_valid_o,
  output logic [1:0]           state_o
);

`ifdef ISSUE_SCHED_DUAL_EN
  localparam bit DUAL_EN = 1'b1;
`else
  localparam bit DUAL_EN = 1'b0;
`endif

  localparam logic [1:0] UPD_NONE = 2'b00;
  localparam logic [1:0] UPD_ONE  = 2'b01;
  localparam logic [1:0] UPD_TWO  = 2'b11;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_DS = 2'd1,
    SERIAL  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       slot0_valid;
  logic       pair_valid;
  logic       raw;
  logic       dual;
  logic       grant;
  logic [1:0] upd;

  // Queue occupancy, slot0->slot1 RAW check, dual candidacy and grant
  // (10 on iq_valid is treated as an empty queue).
  always_comb begin
    slot0_valid = iq_valid_i[0];
    pair_valid  = iq_valid_i[0] & iq_valid_i[1];
    raw         = (dst_i[0] != '0) &&
                  ((dst_i[0] == src0_i[1]) || (dst_i[0] == src1_i[1]));
    dual        = DUAL_EN && pair_valid && (is_serial_i == 2'b00) &&
                  !is_branch_i[1] && !raw;
    grant       = rst && !flush_i && ds_ready_i && slot0_valid &&
                  (state != SERIAL);
  end

  // Next state and dequeue count; nothing moves without a grant, flush wins.
  always_comb begin
    state_nxt = state;
    upd       = UPD_NONE;
    case (state)
      RUN: begin
        if (is_serial_i[0]) begin
          upd = UPD_ONE;
          if (grant) state_nxt = SERIAL;
        end else if (is_branch_i[0]) begin
          if (!pair_valid) begin
            upd = UPD_NONE;
          end else if (dual) begin
            upd = UPD_TWO;
          end else begin
            upd = UPD_ONE;
            if (grant) state_nxt = WAIT_DS;
          end
        end else begin
          upd = dual ? UPD_TWO : UPD_ONE;
        end
      end
      WAIT_DS: begin
        upd = UPD_ONE;
        if (grant) state_nxt = is_serial_i[0] ? SERIAL : RUN;
      end
      SERIAL: begin
        upd = UPD_NONE;
        if (serial_done_i) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    if (!grant) upd = UPD_NONE;
    if (flush_i) state_nxt = RUN;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  assign upd_mode_o    = upd;
  assign issue_valid_o = upd;
  assign state_o       = rst ? 2'(state) : 2'(RUN);

endmodule

// File: tb/tb_issue_sched.sv
// Testbench for issue_sched: directed vector table for the scenario
// sequences, then randomized cycles against a count-based reference model.
module tb_issue_sched;

`ifdef ISSUE_SCHED_DUAL_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif
  localparam logic [1:0] PAIR = DE ? 2'b11 : 2'b01;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic [1:0]      iq_valid_i;
  logic [1:0]      is_branch_i;
  logic [1:0]      is_serial_i;
  logic [1:0][4:0] src0_i;
  logic [1:0][4:0] src1_i;
  logic [1:0][4:0] dst_i;
  logic            ds_ready_i;
  logic            serial_done_i;
  logic [1:0]      upd_mode_o;
  logic [1:0]      issue_valid_o;
  logic [1:0]      state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_sched dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .iq_valid_i    (iq_valid_i),
    .is_branch_i   (is_branch_i),
    .is_serial_i   (is_serial_i),
    .src0_i        (src0_i),
    .src1_i        (src1_i),
    .dst_i         (dst_i),
    .ds_ready_i    (ds_ready_i),
    .serial_done_i (serial_done_i),
    .upd_mode_o    (upd_mode_o),
    .issue_valid_o (issue_valid_o),
    .state_o       (state_o)
  );

  typedef struct {
    logic       r;
    logic       fl;
    logic [1:0] iqv;
    logic [1:0] br;
    logic [1:0] ser;
    logic [4:0] d0;
    logic [4:0] s01;
    logic [4:0] s11;
    logic       dsr;
    logic       sd;
    logic [1:0] eu;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic fl, input logic [1:0] iqv,
                              input logic [1:0] br, input logic [1:0] ser,
                              input int d0, input int s01, input int s11,
                              input logic dsr, input logic sd,
                              input logic [1:0] eu, input logic [1:0] es);
    vec_t v;
    v.r = r; v.fl = fl; v.iqv = iqv; v.br = br; v.ser = ser;
    v.d0 = 5'(d0); v.s01 = 5'(s01); v.s11 = 5'(s11);
    v.dsr = dsr; v.sd = sd; v.eu = eu; v.es = es;
    return v;
  endfunction

  task automatic drive(input logic r, input logic fl, input logic [1:0] iqv,
                       input logic [1:0] br, input logic [1:0] ser,
                       input logic [4:0] d0, input logic [4:0] s00, input logic [4:0] s10,
                       input logic [4:0] s01, input logic [4:0] s11, input logic [4:0] d1,
                       input logic dsr, input logic sd);
    rst = r; flush_i = fl; iq_valid_i = iqv; is_branch_i = br; is_serial_i = ser;
    dst_i[0] = d0; dst_i[1] = d1;
    src0_i[0] = s00; src1_i[0] = s10; src0_i[1] = s01; src1_i[1] = s11;
    ds_ready_i = dsr; serial_done_i = sd;
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] got,
                       input logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s #%0d: got %b want %b", name, idx, got, want);
    end
  endtask

  // Reference: how many instructions leave this cycle and where the
  // scheduler stands next, from the issue rules stated as counts.
  task automatic ref_step(input int st, input logic r, input logic fl,
                          input logic [1:0] iqv, input logic [1:0] br,
                          input logic [1:0] ser, input logic [4:0] d0,
                          input logic [4:0] s01, input logic [4:0] s11,
                          input logic dsr, input logic sd,
                          output logic [1:0] upd, output int nst);
    int  queued;
    int  issued;
    int  after_issue;
    bit  hazard;
    bit  pair_ok;
    bit  allowed;
    queued  = (iqv == 2'b11) ? 2 : (iqv == 2'b01) ? 1 : 0;
    hazard  = (d0 != 0) && (d0 == s01 || d0 == s11);
    pair_ok = DE && queued == 2 && ser == 2'b00 && !br[1] && !hazard;
    allowed = r && !fl && dsr && queued >= 1 && st != 2;
    issued = 0;
    after_issue = 0;
    if (st == 0) begin
      if (ser[0])          begin issued = 1; after_issue = 2; end
      else if (br[0]) begin
        if (queued < 2)    issued = 0;
        else if (pair_ok)  issued = 2;
        else               begin issued = 1; after_issue = 1; end
      end else             issued = pair_ok ? 2 : 1;
    end else if (st == 1) begin
      issued = 1;
      after_issue = ser[0] ? 2 : 0;
    end
    nst = st;
    if (allowed && issued > 0) nst = after_issue;
    else issued = 0;
    if (st == 2 && sd) nst = 0;
    if (fl || !r) nst = 0;
    upd = (issued == 2) ? 2'b11 : (issued == 1) ? 2'b01 : 2'b00;
  endtask

  initial begin
    vec_t        v;
    logic [1:0]  exp_upd;
    int          mst;
    int          nst;
    logic        r, fl, dsr, sd;
    logic [1:0]  iqv, br, ser;
    logic [4:0]  d0, d1, s00, s10, s01, s11;

    // reset
    vecs.push_back(mk(0,0,2'b11,2'b00,2'b00, 5, 6, 7,1,0,2'b00,2'd0));
    vecs.push_back(mk(0,0,2'b11,2'b01,2'b01, 0, 0, 0,1,1,2'b00,2'd0));
    // basic dual issue
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 5, 6, 7,1,0,PAIR ,2'd0));
    // RAW split, then former slot1 issues
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 5, 5, 7,1,0,2'b01,2'd0));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b00, 8, 0, 0,1,0,2'b01,2'd0));
    // jal with RAW on its delay slot
    vecs.push_back(mk(1,0,2'b11,2'b01,2'b00,31,31, 0,1,0,2'b01,2'd0));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b00, 8, 0, 0,1,0,2'b01,2'd1));
    vecs.push_back(mk(1,0,2'b00,2'b00,2'b00, 0, 0, 0,1,0,2'b00,2'd0));
    // serial sequence
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b01, 0, 0, 0,1,0,2'b01,2'd0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 5, 6, 7,1,0,2'b00,2'd2));
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 5, 6, 7,1,1,2'b00,2'd2));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b00, 0, 0, 0,1,0,2'b01,2'd0));
    // short queue holds branch, then back-pressure in WAIT_DS
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,2'b01,2'b01,2'b00, 0, 0, 0,1,0,2'b00,2'd0));
    vecs.push_back(mk(1,0,2'b11,2'b01,2'b00, 0, 0, 0,1,0,PAIR ,2'd0));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b00, 0, 0, 0,1,0,2'b01,DE ? 2'd0 : 2'd1));
    vecs.push_back(mk(1,0,2'b11,2'b01,2'b00,31,31, 0,1,0,2'b01,2'd0));
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 0, 0, 0,0,0,2'b00,2'd1));
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 0, 0, 0,0,0,2'b00,2'd1));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b00, 0, 0, 0,1,0,2'b01,2'd1));
    // flush in SERIAL
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b01, 0, 0, 0,1,0,2'b01,2'd0));
    vecs.push_back(mk(1,1,2'b11,2'b00,2'b00, 0, 0, 0,1,0,2'b00,2'd2));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b00, 0, 0, 0,1,0,2'b01,2'd0));
    // reset in WAIT_DS
    vecs.push_back(mk(1,0,2'b11,2'b01,2'b00,31,31, 0,1,0,2'b01,2'd0));
    vecs.push_back(mk(0,0,2'b11,2'b00,2'b00, 0, 0, 0,1,0,2'b00,2'd0));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b00, 0, 0, 0,1,0,2'b01,2'd0));
    // serial_done in RUN ignored, iq_valid 10, serial in slot1
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 5, 6, 7,1,1,PAIR ,2'd0));
    vecs.push_back(mk(1,0,2'b10,2'b00,2'b00, 0, 0, 0,1,0,2'b00,2'd0));
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b10, 0, 0, 0,1,0,2'b01,2'd0));
    // serial delay slot goes to SERIAL
    vecs.push_back(mk(1,0,2'b11,2'b01,2'b10, 0, 0, 0,1,0,2'b01,2'd0));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b01, 0, 0, 0,1,0,2'b01,2'd1));
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 0, 0, 0,1,0,2'b00,2'd2));
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 0, 0, 0,1,1,2'b00,2'd2));
    vecs.push_back(mk(1,0,2'b00,2'b00,2'b00, 0, 0, 0,1,0,2'b00,2'd0));
    // branch in the delay slot
    vecs.push_back(mk(1,0,2'b11,2'b11,2'b00, 0, 0, 0,1,0,2'b01,2'd0));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b00, 0, 0, 0,1,0,2'b01,2'd1));
    vecs.push_back(mk(1,0,2'b00,2'b00,2'b00, 0, 0, 0,1,0,2'b00,2'd0));
    // flush in WAIT_DS
    vecs.push_back(mk(1,0,2'b11,2'b01,2'b00,31,31, 0,1,0,2'b01,2'd0));
    vecs.push_back(mk(1,1,2'b11,2'b00,2'b00, 0, 0, 0,1,0,2'b00,2'd1));
    vecs.push_back(mk(1,0,2'b01,2'b00,2'b00, 0, 0, 0,1,0,2'b01,2'd0));
    // RAW through src1, stall in RUN
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 4, 0, 4,1,0,2'b01,2'd0));
    vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 0, 0, 0,0,0,2'b00,2'd0));

    drive(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,1,0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.r, v.fl, v.iqv, v.br, v.ser, v.d0, 5'd1, 5'd2, v.s01, v.s11, 5'd9, v.dsr, v.sd);
      #2;
      check("vec_upd",   i, upd_mode_o,    v.eu);
      check("vec_ivld",  i, issue_valid_o, v.eu);
      check("vec_state", i, state_o,       v.es);
      @(posedge clk); #1;
    end

    // randomized cycles against the reference
    mst = 0;
    for (int c = 0; c < 2000; c++) begin
      r   = ($urandom % 24) != 0;
      fl  = ($urandom % 16) == 0;
      case ($urandom % 8)
        0:       iqv = 2'b00;
        1:       iqv = 2'b10;
        2, 3:    iqv = 2'b01;
        default: iqv = 2'b11;
      endcase
      br  = {($urandom % 4) == 0, ($urandom % 3) == 0};
      ser = {($urandom % 8) == 0, ($urandom % 8) == 0};
      d0  = 5'($urandom % 6);  d1  = 5'($urandom % 6);
      s00 = 5'($urandom % 6);  s10 = 5'($urandom % 6);
      s01 = 5'($urandom % 6);  s11 = 5'($urandom % 6);
      dsr = ($urandom % 4) != 0;
      sd  = ($urandom % 3) == 0;
      drive(r, fl, iqv, br, ser, d0, s00, s10, s01, s11, d1, dsr, sd);
      ref_step(mst, r, fl, iqv, br, ser, d0, s01, s11, dsr, sd, exp_upd, nst);
      #2;
      check("rnd_upd",   c, upd_mode_o,    exp_upd);
      check("rnd_ivld",  c, issue_valid_o, exp_upd);
      check("rnd_state", c, state_o,       r ? 2'(mst) : 2'd0);
      @(posedge clk); #1;
      mst = nst;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 SHALL have: clk  input  1  clock, rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: flush_i  input  1  pipeline flush, branch mispredict or exception.
REQ-004 SHALL have: iq_valid_i  input  2  head-entry valids from instruction queue; legal values 00, 01, 11.
REQ-005 SHALL have: is_branch_i  input  2  per-slot branch/jump flag.
REQ-006 SHALL have: is_serial_i  input  2  per-slot must-issue-alone flag (CP0, eret, syscall, cache, tlb*).
REQ-007 SHALL have: src0_i, src1_i  input  2x5 each  per-slot source register numbers (rs, rt packed).
REQ-008 SHALL have: dst_i  input  2x5  per-slot destination register; 0 means none.
REQ-009 SHALL have: ds_ready_i  input  1  downstream issue stage accepts this cycle.
REQ-010 SHALL have: serial_done_i  input  1  backend has retired the serial instruction.
REQ-011 SHALL have: upd_mode_o  output  2  dequeue count to queue: 00 none, 01 one, 11 two.
REQ-012 SHALL have: issue_valid_o  output  2  slot valids presented downstream; equals upd_mode_o.
REQ-013 SHALL have: state_o  output  2  current state: 0 RUN, 1 WAIT_DS, 2 SERIAL.

Function
REQ-014 Outputs SHALL be combinational from the registered state and the current inputs; the state register SHALL update on clk.
REQ-015 upd_mode_o SHALL be 00 whenever any of these hold: flush_i=1, ds_ready_i=0, iq_valid_i[0]=0, or state=SERIAL.
REQ-016 Dual-issue candidacy SHALL require all of: iq_valid_i=11, is_serial_i=00, is_branch_i[1]=0, and no RAW hazard.
- RAW hazard: dst_i[0]!=0 and dst_i[0] equals src0_i[1] or src1_i[1].
REQ-017 In RUN, with slot0 a non-branch, non-serial instruction: output 11 if dual candidate, else 01.
REQ-018 In RUN, with slot0 a branch:
- If iq_valid_i=01: output 00; the branch SHALL NOT leave without its delay slot while the queue is short.
- If dual candidate: output 11; the branch and its delay slot issue together.
- Otherwise (RAW, serial delay slot, or branch delay slot): output 01 and go to WAIT_DS.
REQ-019 In WAIT_DS, slot0 is the delay slot:
- It SHALL issue alone (01) when slot0 is valid and ds_ready_i=1, then return to RUN.
- A serial delay slot SHALL go to SERIAL instead.
REQ-020 In RUN, with slot0 serial: output 01 and go to SERIAL. Slot1 SHALL never issue alongside a serial instruction.
REQ-021 SERIAL SHALL hold output 00 until serial_done_i=1, then go to RUN in the next cycle. serial_done_i outside SERIAL SHALL be ignored.
REQ-022 flush_i=1 SHALL force the next state to RUN from any state, with priority over all other transitions.
REQ-023 A transition out of any state SHALL occur only in a cycle where issue is actually granted, or on serial_done_i/flush_i. ds_ready_i=0 SHALL hold the state.
REQ-024 upd_mode_o SHALL never be 10; iq_valid_i=10 SHALL be treated as 00.

Reset
REQ-025 With rst=0 at a clk edge, state SHALL become RUN.
REQ-026 While rst=0, upd_mode_o and issue_valid_o SHALL be 00 and state_o SHALL be 0.
REQ-027 Reset asserted mid-SERIAL or mid-WAIT_DS SHALL abandon that state with no pending issue.

Configuration
REQ-028 Macro ISSUE_SCHED_DUAL_EN SHALL control dual issue.
- Defined: behaviour as REQ-016 to REQ-018.
- Undefined: dual candidacy is always false, so every issue is 01, and every branch in RUN passes through WAIT_DS.

Verification
REQ-029 Basic dual issue: RUN, iq_valid=11, ds_ready=1, dst0=5, slot1 sources 6/7, no branch or serial -> upd_mode=11, state stays 0.
REQ-030 RAW split: dst0=5, src0[1]=5 -> upd_mode=01; next cycle the same slot1 is now slot0 and issues.
REQ-031 Branch with RAW:
- slot0 branch (jal, dst=31), slot1 src=31 -> upd_mode=01, state becomes 1.
- Next cycle iq_valid=01 -> upd_mode=01, state becomes 0.
REQ-032 Serial sequence:
- slot0 serial -> 01, state becomes 2.
- Then 3 cycles of serial_done=0 -> 00 each cycle.
- serial_done=1 -> state 0 next cycle.
REQ-033 Short queue and back-pressure:
- slot0 branch, iq_valid=01 -> 00 for 4 cycles; then iq_valid=11 -> 11.
- ds_ready=0 in WAIT_DS -> 00, state held.
REQ-034 Flush and reset: flush_i=1 in SERIAL -> 00 that cycle, state 0 next cycle; rst=0 in WAIT_DS -> state 0 and outputs 00.
